// File: rtl/mips_pkg.sv
// Shared pipeline types for the hazard/forwarding logic: forward-select
// encoding, the $zero register and the per-stage tracking slot.
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } slot_t;

  // EX also keeps its sources so forwarding can be resolved there.
  typedef struct packed {
    slot_t            slot;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
  } ex_slot_t;

  function automatic logic writes_to(slot_t s, logic [REG_W-1:0] r);
    return s.valid & s.reg_write & (s.dest == r);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand source select for one EX operand; MEM result beats WB result.
module fwd_select
  import mips_pkg::*;
(
  input  slot_t            mem_slot,
  input  slot_t            wb_slot,
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_REG;
    if (uses && src != REG_ZERO) begin
      // A load in MEM has no data yet; it can only be forwarded from WB.
      if (writes_to(mem_slot, src) && !mem_slot.mem_read) sel = FWD_MEM;
      else if (writes_to(wb_slot, src))                    sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks in-flight register writes through EX/MEM/WB, drives EX operand
// forwarding and the load-use stall / bubble control.
module hazard_forward_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_W,
  parameter int LOAD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  freeze,
  input  logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic                  ex_bubble
);

  localparam int CNT_W = $clog2(LOAD_LATENCY + 1);

  ex_slot_t         ex_q, ex_d, id_entry;
  slot_t            mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;
  fwd_sel_t         fwd_a_sel, fwd_b_sel;

  // Writes to $zero are dropped at entry so nothing downstream matches r0.
  always_comb begin
    id_entry                = '0;
    id_entry.slot.valid     = id_valid;
    id_entry.slot.dest      = id_dest;
    id_entry.slot.reg_write = id_reg_write & (id_dest != REG_ZERO);
    id_entry.slot.mem_read  = id_mem_read;
    id_entry.rs             = id_rs;
    id_entry.rt             = id_rt;
    id_entry.uses_rs        = id_uses_rs;
    id_entry.uses_rt        = id_uses_rt;
  end

  always_comb begin
    hazard = id_valid & ex_q.slot.valid & ex_q.slot.mem_read & ex_q.slot.reg_write &
             ((id_uses_rs & (id_rs == ex_q.slot.dest)) |
              (id_uses_rt & (id_rt == ex_q.slot.dest)));
    stall  = hazard | (stall_cnt_q != '0);
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q.slot;
      ex_d  = (stall || flush || !id_valid) ? '0 : id_entry;
      // Flush kills the stalled consumer, so any owed stall cycles go too.
      if (flush)                    stall_cnt_d = '0;
      else if (stall_cnt_q != '0)   stall_cnt_d = stall_cnt_q - 1'b1;
      else if (hazard)              stall_cnt_d = CNT_W'(LOAD_LATENCY - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  fwd_select u_fwd_a (
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .src      (ex_q.rs),
    .uses     (ex_q.uses_rs),
    .sel      (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .src      (ex_q.rt),
    .uses     (ex_q.uses_rt),
    .sel      (fwd_b_sel)
  );

  assign fwd_a     = fwd_a_sel;
  assign fwd_b     = fwd_b_sel;
  assign ex_bubble = ~ex_q.slot.valid;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Two DUTs (load latency 1 and 3) share stimulus; a queue-based scoreboard
// checks them against an instruction-level pipeline model.
module tb_hazard_forward_unit;

  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; int dest; bit rw; bit mr;
  } ins_t;

  typedef struct {
    string tag; int inst; int fa; int fb; bit st; bit eb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic       freeze, flush;
  logic [4:0] id_rs, id_rt, id_dest;
  logic [1:0][1:0] fwd_a, fwd_b;
  logic [1:0]      stall, ex_bubble;

  hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .freeze(freeze),
    .flush(flush), .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall(stall[0]),
    .ex_bubble(ex_bubble[0])
  );

  hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .freeze(freeze),
    .flush(flush), .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall(stall[1]),
    .ex_bubble(ex_bubble[1])
  );

  int   lat [2] = '{1, 3};
  ins_t mex [2];
  ins_t mmem[2];
  ins_t mwb [2];
  int   left[2];
  exp_t sbq[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;

  function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr);
    ins_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.dest = dest; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  // An instruction architecturally produces register r (r0 never counts).
  function automatic bit wr(ins_t s, int r);
    return s.v && s.rw && s.dest != 0 && s.dest == r;
  endfunction

  function automatic int fsel(ins_t m, ins_t w, int src, bit u);
    if (!u) return 0;
    if (wr(m, src) && !m.mr) return 2;
    if (wr(w, src)) return 1;
    return 0;
  endfunction

  function automatic bit load_use(ins_t e, ins_t id);
    return id.v && e.mr && wr(e, e.dest) &&
           ((id.urs && id.rs == e.dest) || (id.urt && id.rt == e.dest));
  endfunction

  task automatic chk(string tag, string nm, int inst, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s %s lat%0d: got %0d expected %0d", tag, nm, lat[inst], act, exp);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk(mon_e.tag, "fwd_a",     mon_e.inst, int'(fwd_a[mon_e.inst]),     mon_e.fa);
      chk(mon_e.tag, "fwd_b",     mon_e.inst, int'(fwd_b[mon_e.inst]),     mon_e.fb);
      chk(mon_e.tag, "stall",     mon_e.inst, int'(stall[mon_e.inst]),     int'(mon_e.st));
      chk(mon_e.tag, "ex_bubble", mon_e.inst, int'(ex_bubble[mon_e.inst]), int'(mon_e.eb));
    end
  end

  // Drive one cycle, queue the expected outputs, then advance the model.
  task automatic step(input ins_t id, input bit rst, input bit frz, input bit fl,
                      input string tag, output bit stall_any);
    bit   st[2];
    bit   h;
    exp_t e;
    ins_t bub;
    bub          = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n        = rst;
    freeze       = frz;
    flush        = fl;
    id_valid     = id.v;
    id_rs        = 5'(id.rs);
    id_rt        = 5'(id.rt);
    id_uses_rs   = id.urs;
    id_uses_rt   = id.urt;
    id_dest      = 5'(id.dest);
    id_reg_write = id.rw;
    id_mem_read  = id.mr;
    stall_any    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st[k]  = left[k] > 0 || load_use(mex[k], id);
      e.tag  = tag;
      e.inst = k;
      e.fa   = fsel(mmem[k], mwb[k], mex[k].rs, mex[k].urs);
      e.fb   = fsel(mmem[k], mwb[k], mex[k].rt, mex[k].urt);
      e.st   = st[k];
      e.eb   = !mex[k].v;
      sbq.push_back(e);
      stall_any |= st[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mex[k] = bub; mmem[k] = bub; mwb[k] = bub; left[k] = 0;
      end else if (!frz) begin
        h       = load_use(mex[k], id);
        mwb[k]  = mmem[k];
        mmem[k] = mex[k];
        mex[k]  = (!st[k] && !fl && id.v) ? id : bub;
        if (fl)               left[k] = 0;
        else if (left[k] > 0) left[k] = left[k] - 1;
        else if (h)           left[k] = lat[k] - 1;
      end
    end
    #1;
  endtask

  // Present an instruction until neither pipeline is stalling on it.
  task automatic issue(input ins_t id, input string tag);
    bit s;
    int n;
    n = 0;
    do begin
      step(id, 1'b1, 1'b0, 1'b0, tag, s);
      n++;
    end while (s && n < 8);
  endtask

  task automatic nops(input int n, input string tag);
    bit s;
    for (int i = 0; i < n; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, tag, s);
  endtask

  initial begin
    bit   s;
    ins_t rd;
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; id_valid = 1'b1;
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_dest = 5'd4; id_reg_write = 1'b1; id_mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) step(mk(1, 1, 2, 1, 1, 4, 1, 0), 1'b0, 1'b0, 1'b0, "reset", s);
    issue(mk(1, 1, 2, 1, 1, 4, 1, 0), "first");
    nops(3, "first");

    issue(mk(1, 1, 2, 1, 1, 3, 1, 0), "alu_fwd");
    issue(mk(1, 3, 4, 1, 1, 8, 1, 0), "alu_fwd");
    issue(mk(1, 9, 3, 1, 1, 10, 1, 0), "alu_fwd");
    nops(3, "alu_fwd");

    issue(mk(1, 1, 0, 1, 0, 5, 1, 1), "load_use");
    issue(mk(1, 5, 2, 1, 1, 11, 1, 0), "load_use");
    nops(4, "load_use");

    issue(mk(1, 1, 2, 1, 1, 0, 1, 1), "zero");
    issue(mk(1, 0, 0, 1, 1, 12, 1, 0), "zero");
    issue(mk(1, 3, 2, 1, 1, 0, 1, 0), "zero");
    issue(mk(1, 0, 0, 1, 1, 13, 1, 0), "zero");
    nops(3, "zero");

    issue(mk(1, 1, 2, 1, 1, 7, 1, 0), "priority");
    issue(mk(1, 1, 2, 1, 1, 7, 1, 0), "priority");
    issue(mk(1, 7, 7, 1, 1, 14, 1, 0), "priority");
    nops(3, "priority");

    rd = mk(1, 2, 6, 1, 1, 15, 1, 0);
    issue(mk(1, 1, 0, 1, 0, 6, 1, 1), "freeze");
    step(rd, 1'b1, 1'b0, 1'b0, "freeze", s);
    for (int i = 0; i < 4; i++) step(rd, 1'b1, 1'b1, 1'b0, "freeze", s);
    issue(rd, "freeze");
    nops(4, "freeze");

    issue(mk(1, 1, 0, 1, 0, 9, 1, 1), "flush");
    step(mk(1, 9, 0, 1, 0, 16, 1, 0), 1'b1, 1'b0, 1'b1, "flush", s);
    nops(4, "flush");

    issue(mk(1, 1, 0, 1, 0, 9, 1, 1), "mid_reset");
    step(mk(1, 9, 0, 1, 0, 16, 1, 0), 1'b1, 1'b0, 1'b0, "mid_reset", s);
    step(mk(1, 9, 0, 1, 0, 16, 1, 0), 1'b0, 1'b0, 1'b0, "mid_reset", s);
    nops(3, "mid_reset");

    for (int i = 0; i < 500; i++) begin
      rd = mk($urandom_range(0, 99) < 80, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 35);
      step(rd, $urandom_range(0, 199) != 0, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 8, "random", s);
    end

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
